uart_link_ctl: RTL

UART_LINK_CTL -- requirements
Module: uart_link_ctl

---
 rtl/uart_link_pkg.sv | 25 ++
 rtl/uart_link_ctl_rx_parser.sv | 88 ++++++++
 rtl/uart_link_ctl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_link_pkg.sv
// Shared definitions for the game link: game-state encoding, message codes
// and the FSM state types used by the UART link controller.
package uart_link_pkg;

    typedef enum logic [1:0] {
        GS_IDLE  = 2'b00,
        GS_WAIT  = 2'b01,
        GS_GAME  = 2'b10,
        GS_SCORE = 2'b11
    } game_state_t;

    localparam logic [7:0] START_CODE_DEF = 8'hA5;
    localparam logic [7:0] SCORE_CODE_DEF = 8'h53;
    localparam logic [7:0] MAX_SCORE      = 8'd99;

    typedef enum logic [1:0] {T_IDLE, T_LAUNCH, T_WAIT} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_SCORE, R_CHK} rx_state_t;
    typedef enum logic {MSG_START, MSG_SCORE} msg_t;

    // Third byte of a score message: protects the score byte against corruption.
    function automatic logic [7:0] score_check(input logic [7:0] code, input logic [7:0] score);
        return code ^ score;
    endfunction

endpackage

// File: rtl/uart_link_ctl_rx_parser.sv
// Receive-side parser: recognises the player-ready byte and the three-byte
// score message, validates it and flags protocol errors and inter-byte timeouts.
module uart_rx_parser
    import uart_link_pkg::*;
#(
    parameter logic [7:0]  START_CODE = START_CODE_DEF,
    parameter logic [7:0]  SCORE_CODE = SCORE_CODE_DEF,
    parameter int unsigned RX_TIMEOUT = 75000
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       clr,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       uart_start,
    output logic [6:0] op_score,
    output logic       op_score_valid,
    output logic       link_error
);

    localparam int CW = $clog2(RX_TIMEOUT + 1);

    rx_state_t     rx_state;
    logic [7:0]    cap;
    logic [CW-1:0] idle_cnt;
    logic          timed_out;

    assign timed_out = (idle_cnt == CW'(RX_TIMEOUT - 1));

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            rx_state       <= R_IDLE;
            cap            <= '0;
            idle_cnt       <= '0;
            uart_start     <= 1'b0;
            op_score       <= '0;
            op_score_valid <= 1'b0;
            link_error     <= 1'b0;
        end else begin
            uart_start <= 1'b0;
            if (clr) begin
                op_score_valid <= 1'b0;
                link_error     <= 1'b0;
            end
            // Counts silent cycles only while a score message is half-received.
            if (rx_state == R_IDLE || rx_done)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;

            case (rx_state)
                R_IDLE: begin
                    if (rx_done) begin
                        if (rx_data == START_CODE)
                            uart_start <= 1'b1;
                        else if (rx_data == SCORE_CODE)
                            rx_state <= R_SCORE;
                    end
                end
                R_SCORE: begin
                    if (rx_done) begin
                        cap      <= rx_data;
                        rx_state <= R_CHK;
                    end else if (timed_out) begin
                        link_error <= 1'b1;
                        rx_state   <= R_IDLE;
                    end
                end
                R_CHK: begin
                    if (rx_done) begin
                        if (rx_data == score_check(SCORE_CODE, cap) && cap <= MAX_SCORE) begin
                            op_score       <= cap[6:0];
                            op_score_valid <= 1'b1;
                        end else begin
                            link_error <= 1'b1;
                        end
                        rx_state <= R_IDLE;
                    end else if (timed_out) begin
                        link_error <= 1'b1;
                        rx_state   <= R_IDLE;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_link_ctl.sv
// UART link controller: sequences the outgoing ready/score messages around a
// byte-level UART transmitter and hosts the receive parser.
module uart_link_ctl
    import uart_link_pkg::*;
#(
    parameter logic [7:0]  START_CODE = START_CODE_DEF,
    parameter logic [7:0]  SCORE_CODE = SCORE_CODE_DEF,
    parameter int unsigned RX_TIMEOUT = 75000
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic [1:0] state,
    input  logic       rect_clicked_play,
    input  logic [6:0] my_score,
    input  logic       tx_busy,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       uart_start,
    output logic [6:0] op_score,
    output logic       op_score_valid,
    output logic       link_error
);

    tx_state_t  tx_state;
    msg_t       cur_msg;
    logic [1:0] byte_idx;
    logic [7:0] score_byte;
    logic [1:0] prev_state;
    logic       start_pend;
    logic       score_pend;

    logic play_req, score_entry, back_to_idle, start_req, score_req;

    assign play_req     = rect_clicked_play && (state == GS_IDLE);
    assign score_entry  = (state == GS_SCORE) && (prev_state != GS_SCORE);
    assign back_to_idle = (state == GS_IDLE) && (prev_state != GS_IDLE);
    // Same-cycle requests launch immediately instead of waiting for the flag.
    assign start_req    = start_pend || play_req;
    assign score_req    = score_pend || score_entry;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            tx_state   <= T_IDLE;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            cur_msg    <= MSG_START;
            byte_idx   <= '0;
            score_byte <= '0;
            prev_state <= GS_IDLE;
            start_pend <= 1'b0;
            score_pend <= 1'b0;
        end else begin
            prev_state <= state;
            tx_start   <= 1'b0;

            case (tx_state)
                T_IDLE: begin
                    if (!tx_busy && (start_req || score_req)) begin
                        tx_start <= 1'b1;
                        tx_state <= T_LAUNCH;
                        byte_idx <= 2'd0;
                        if (start_req) begin
                            cur_msg <= MSG_START;
                            tx_data <= START_CODE;
                        end else begin
                            cur_msg    <= MSG_SCORE;
                            tx_data    <= SCORE_CODE;
                            score_byte <= {1'b0, my_score};
                        end
                    end
                end
                T_LAUNCH: tx_state <= T_WAIT;
                T_WAIT: begin
                    if (!tx_busy) begin
                        // A dropped score request abandons the rest of its message.
                        if (cur_msg == MSG_SCORE && score_pend && byte_idx != 2'd2) begin
                            byte_idx <= byte_idx + 2'd1;
                            tx_start <= 1'b1;
                            tx_state <= T_LAUNCH;
                            tx_data  <= (byte_idx == 2'd0) ? score_byte
                                                           : score_check(SCORE_CODE, score_byte);
                        end else begin
                            tx_state <= T_IDLE;
                            if (cur_msg == MSG_START)
                                start_pend <= 1'b0;
                            else
                                score_pend <= 1'b0;
                        end
                    end
                end
                default: tx_state <= T_IDLE;
            endcase

            if (back_to_idle) begin
                start_pend <= 1'b0;
                score_pend <= 1'b0;
            end
            if (play_req)
                start_pend <= 1'b1;
            if (score_entry)
                score_pend <= 1'b1;
        end
    end

    uart_rx_parser #(
        .START_CODE (START_CODE),
        .SCORE_CODE (SCORE_CODE),
        .RX_TIMEOUT (RX_TIMEOUT)
    ) u_rx_parser (
        .pclk           (pclk),
        .rst            (rst),
        .clr            (back_to_idle),
        .rx_done        (rx_done),
        .rx_data        (rx_data),
        .uart_start     (uart_start),
        .op_score       (op_score),
        .op_score_valid (op_score_valid),
        .link_error     (link_error)
    );

endmodule
